// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Two-way intersection phase controller. Steps the north-south (NS) and
// east-west (EW) signal heads through NS green -> NS yellow -> EW green ->
// EW yellow on a 1 s tick derived from clk. Publishes per-direction seconds
// remaining for the seven-segment display, and lets a pedestrian key pulse
// cut the current green short.
//
// Parameters:
//   TICK_CYCLES  clk cycles per 1 s tick
//   GREEN_S      green duration in seconds (2..96)
//   YELLOW_S     yellow duration in seconds (1..99-GREEN_S)
//   PED_S        green seconds left after a pedestrian request (1..GREEN_S-1)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   key_flag  in   one-cycle pedestrian request pulse
//   ns_light  out  NS head, one-hot {red, yellow, green}
//   ew_light  out  EW head, one-hot {red, yellow, green}
//   dat1      out  seconds until the NS head changes (binary 0..99)
//   dat2      out  seconds until the EW head changes (binary 0..99)
//   phase     out  current state code (0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y)
// -----------------------------------------------------------------------------
module traffic_phase_ctrl #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int GREEN_S     = 20,
    parameter int YELLOW_S    = 3,
    parameter int PED_S       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [7:0] dat1,
    output logic [7:0] dat2,
    output logic [1:0] phase
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [7:0]       GREEN_V  = 8'(GREEN_S);
    localparam logic [7:0]       YELLOW_V = 8'(YELLOW_S);
    localparam logic [7:0]       PED_V    = 8'(PED_S);

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    typedef enum logic [1:0] {
        NS_G = 2'd0,
        NS_Y = 2'd1,
        EW_G = 2'd2,
        EW_Y = 2'd3
    } state_e;

    // Fixed ring order; there is no other transition.
    function automatic state_e next_state(input state_e s);
        state_e n;
        case (s)
            NS_G:    n = NS_Y;
            NS_Y:    n = EW_G;
            EW_G:    n = EW_Y;
            EW_Y:    n = NS_G;
            default: n = NS_G;
        endcase
        return n;
    endfunction

    // Duration loaded into rem on entry to a state.
    function automatic logic [7:0] phase_dur(input state_e s);
        logic [7:0] d;
        case (s)
            NS_G, EW_G: d = GREEN_V;
            NS_Y, EW_Y: d = YELLOW_V;
            default:    d = GREEN_V;
        endcase
        return d;
    endfunction

    function automatic logic is_green(input state_e s);
        logic g;
        case (s)
            NS_G, EW_G: g = 1'b1;
            default:    g = 1'b0;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] ns_light_enc(input state_e s);
        logic [2:0] l;
        case (s)
            NS_G:    l = LIGHT_GREEN;
            NS_Y:    l = LIGHT_YELLOW;
            default: l = LIGHT_RED;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] ew_light_enc(input state_e s);
        logic [2:0] l;
        case (s)
            EW_G:    l = LIGHT_GREEN;
            EW_Y:    l = LIGHT_YELLOW;
            default: l = LIGHT_RED;
        endcase
        return l;
    endfunction

    // The red head waits for the other side's remaining green plus its yellow;
    // during a yellow both heads change together, so both show rem.
    function automatic logic [7:0] ns_dat(input state_e s, input logic [7:0] r);
        logic [7:0] d;
        case (s)
            EW_G:    d = r + YELLOW_V;
            default: d = r;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] ew_dat(input state_e s, input logic [7:0] r);
        logic [7:0] d;
        case (s)
            NS_G:    d = r + YELLOW_V;
            default: d = r;
        endcase
        return d;
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ns_light_q, ns_light_d;
    logic [2:0]       ew_light_q, ew_light_d;
    logic [7:0]       dat1_q, dat1_d;
    logic [7:0]       dat2_q, dat2_d;
    logic             tick_s;
    logic             ped_ok_s;

    // Prescaler, tick decode and pedestrian-request qualification.
    always_comb begin
        tick_s   = (cnt_q == CNT_LAST);
        ped_ok_s = key_flag && is_green(state_q) && (rem_q > PED_V);
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Phase/remaining-time update; outputs are decoded from the next values so
    // that the registered outputs move in the same edge as state and rem.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (ped_ok_s) begin
            // A key coincident with a tick wins and discards that decrement.
            rem_d = PED_V;
        end else if (tick_s) begin
            if (rem_q == 8'd1) begin
                state_d = next_state(state_q);
                rem_d   = phase_dur(next_state(state_q));
            end else begin
                rem_d = rem_q - 8'd1;
            end
        end else begin
            rem_d = rem_q;
        end
        ns_light_d = ns_light_enc(state_d);
        ew_light_d = ew_light_enc(state_d);
        dat1_d     = ns_dat(state_d, rem_d);
        dat2_d     = ew_dat(state_d, rem_d);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NS_G;
            rem_q      <= GREEN_V;
            cnt_q      <= '0;
            ns_light_q <= LIGHT_GREEN;
            ew_light_q <= LIGHT_RED;
            dat1_q     <= GREEN_V;
            dat2_q     <= GREEN_V + YELLOW_V;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            ns_light_q <= ns_light_d;
            ew_light_q <= ew_light_d;
            dat1_q     <= dat1_d;
            dat2_q     <= dat2_d;
        end
    end

    assign ns_light = ns_light_q;
    assign ew_light = ew_light_q;
    assign dat1     = dat1_q;
    assign dat2     = dat2_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl with a short tick period.
module tb_traffic_phase_ctrl;

    localparam int T = 4;
    localparam int G = 20;
    localparam int Y = 3;
    localparam int P = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_flag = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] dat1;
    logic [7:0] dat2;
    logic [1:0] phase;

    int n_err = 0;
    int n_checks = 0;
    bit check_en = 1'b0;

    // Reference: phase index (0..3), seconds left, prescaler count.
    int m_ph = 0;
    int m_rem = G;
    int m_cnt = 0;

    traffic_phase_ctrl #(
        .TICK_CYCLES(T), .GREEN_S(G), .YELLOW_S(Y), .PED_S(P)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_flag(key_flag),
        .ns_light(ns_light), .ew_light(ew_light),
        .dat1(dat1), .dat2(dat2), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int dur_of(input int ph);
        return (ph % 2 == 0) ? G : Y;
    endfunction

    // Seconds until a head changes: its own rem while it is lit, otherwise
    // the other side's green plus yellow, or the shared yellow.
    function automatic int exp_dat(input bit ns_dir, input int ph, input int rem);
        bit own_lit = ns_dir ? (ph < 2) : (ph >= 2);
        if (own_lit) return rem;
        return (ph % 2 == 0) ? rem + Y : rem;
    endfunction

    function automatic int exp_light(input bit ns_dir, input int ph);
        int own = ns_dir ? ph : (ph + 2) % 4;
        if (own == 0) return 1;
        if (own == 1) return 2;
        return 4;
    endfunction

    // Reference model following the phase rules second by second.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph  <= 0;
            m_rem <= G;
            m_cnt <= 0;
        end else begin
            m_cnt <= (m_cnt == T - 1) ? 0 : m_cnt + 1;
            if (key_flag && (m_ph % 2 == 0) && m_rem > P) begin
                m_rem <= P;
            end else if (m_cnt == T - 1) begin
                if (m_rem == 1) begin
                    m_ph  <= (m_ph + 1) % 4;
                    m_rem <= dur_of((m_ph + 1) % 4);
                end else begin
                    m_rem <= m_rem - 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, plus invariants.
    always @(negedge clk) begin
        if (check_en) begin
            chk("phase", int'(phase), m_ph);
            chk("ns_light", int'(ns_light), exp_light(1'b1, m_ph));
            chk("ew_light", int'(ew_light), exp_light(1'b0, m_ph));
            chk("dat1", int'(dat1), exp_dat(1'b1, m_ph, m_rem));
            chk("dat2", int'(dat2), exp_dat(1'b0, m_ph, m_rem));
            chk("ns_onehot", $countones(ns_light), 1);
            chk("ew_onehot", $countones(ew_light), 1);
            chk("both_nonred", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_key();
        key_flag = 1'b1;
        @(negedge clk);
        key_flag = 1'b0;
    endtask

    // Wait (bounded) until the model reaches a phase/rem, and a prescaler
    // count when c >= 0.
    task automatic wait_for(input int ph, input int r, input int c, input string nm);
        int n = 0;
        while (!(m_ph == ph && m_rem == r && (c < 0 || m_cnt == c)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout_%s: condition not reached within 2000 cycles", nm);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_phase"}, int'(phase), 0);
        chk({nm, "_ns"}, int'(ns_light), 1);
        chk({nm, "_ew"}, int'(ew_light), 4);
        chk({nm, "_dat1"}, int'(dat1), 20);
        chk({nm, "_dat2"}, int'(dat2), 23);
    endtask

    initial begin
        // 1. Reset
        cyc(3);
        check_en = 1'b1;
        rst_n = 1'b1;
        chk_reset_vals("reset");
        cyc(3);
        chk("pre_tick_dat1", int'(dat1), 20);
        cyc(1);
        chk("first_tick_dat1", int'(dat1), 19);
        chk("first_tick_dat2", int'(dat2), 22);

        // 2. Full cycle (ticks counted from release)
        cyc(76);
        chk("t20_phase", int'(phase), 1);
        chk("t20_dat1", int'(dat1), 3);
        chk("t20_dat2", int'(dat2), 3);
        cyc(4);
        chk("t21_dat1", int'(dat1), 2);
        chk("t21_dat2", int'(dat2), 2);
        cyc(4);
        chk("t22_dat1", int'(dat1), 1);
        cyc(4);
        chk("t23_phase", int'(phase), 2);
        chk("t23_dat1", int'(dat1), 23);
        chk("t23_dat2", int'(dat2), 20);
        cyc(80);
        chk("t43_phase", int'(phase), 3);
        chk("t43_dat2", int'(dat2), 3);
        cyc(12);
        chk("t46_phase", int'(phase), 0);
        chk("t46_dat1", int'(dat1), 20);
        chk("t46_dat2", int'(dat2), 23);

        // 3. Pedestrian shortening at rem=15, prescaler at 0
        wait_for(0, 15, 0, "ped15");
        pulse_key();
        chk("ped_dat1", int'(dat1), 5);
        chk("ped_dat2", int'(dat2), 8);
        cyc(18);
        chk("ped_before_y", int'(phase), 0);
        cyc(1);
        chk("ped_enter_y", int'(phase), 1);
        chk("ped_enter_y_dat1", int'(dat1), 3);

        // 4. Ignored requests
        wait_for(0, 5, 0, "ign5");
        pulse_key();
        chk("ign5_dat1", int'(dat1), 5);
        chk("ign5_dat2", int'(dat2), 8);
        wait_for(0, 3, 0, "ign3");
        pulse_key();
        chk("ign3_dat1", int'(dat1), 3);
        chk("ign3_phase", int'(phase), 0);
        wait_for(3, 2, 0, "ign_ewy");
        pulse_key();
        chk("ign_ewy_phase", int'(phase), 3);
        chk("ign_ewy_dat1", int'(dat1), 2);
        chk("ign_ewy_dat2", int'(dat2), 2);

        // 5. Key coincident with tick in EW_G at rem=12
        wait_for(2, 12, T - 1, "coinc");
        pulse_key();
        chk("coinc_dat2", int'(dat2), 5);
        chk("coinc_dat1", int'(dat1), 8);
        chk("coinc_phase", int'(phase), 2);

        // 6. Asynchronous reset mid EW_Y, between clock edges
        wait_for(3, 2, 1, "rst_ewy");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        chk("restart_phase", int'(phase), 0);
        chk("restart_dat1", int'(dat1), 19);

        // Random key pulses with occasional asynchronous resets
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rand_rst_dat1", int'(dat1), 20);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                key_flag = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
        end
        key_flag = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
